// File: rtl/adder_pkg.sv
// adder_pkg: shared mode encoding and slice sizing for the pipelined adder-subtractor.
package adder_pkg;
    typedef enum logic {MODE_ADD = 1'b0, MODE_SUB = 1'b1} mode_e;
    function automatic int slice_width(int data_width, int num_stages);
        return data_width / num_stages;
    endfunction
endpackage

// File: rtl/adder_slice.sv
// adder_slice: combinational ripple-carry adder for one pipeline slice.
module adder_slice #(
    parameter int SLICE_WIDTH = 4
) (
    input  logic [SLICE_WIDTH-1:0] a,
    input  logic [SLICE_WIDTH-1:0] b,
    input  logic                   cin,
    output logic [SLICE_WIDTH-1:0] sum,
    output logic                   cout
);
    logic c;
    always_comb begin
        sum = '0;
        c = cin;
        for (int i = 0; i < SLICE_WIDTH; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end
endmodule

// File: rtl/pipelined_adder_subtractor.sv
// pipelined_adder_subtractor: carry-pipelined add/sub, one slice per stage,
// with per-stage valid bits and bubble-collapsing backpressure.
module pipelined_adder_subtractor
    import adder_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_STAGES = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic                  C0,
    input  logic                  SUB,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    output logic [DATA_WIDTH-1:0] S,
    output logic                  CF,
    output logic                  OF,
    output logic                  ZF,
    output logic                  NF,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY
);
    localparam int SW  = slice_width(DATA_WIDTH, NUM_STAGES);
    localparam int LS  = NUM_STAGES - 1;
    localparam int MSB = DATA_WIDTH - 1;

    if (DATA_WIDTH % NUM_STAGES != 0) begin : g_bad_width
        $error("DATA_WIDTH must be an integer multiple of NUM_STAGES");
    end

    logic [NUM_STAGES-1:0] v_q, v_d, c_q, c_d, sub_q, sub_d;
    logic [DATA_WIDTH-1:0] a_q [NUM_STAGES];
    logic [DATA_WIDTH-1:0] a_d [NUM_STAGES];
    logic [DATA_WIDTH-1:0] b_q [NUM_STAGES];
    logic [DATA_WIDTH-1:0] b_d [NUM_STAGES];
    logic [DATA_WIDTH-1:0] s_q [NUM_STAGES];
    logic [DATA_WIDTH-1:0] s_d [NUM_STAGES];
    logic [NUM_STAGES:0]   rdy;

    // A stage may load when it is empty or its successor is taking its contents.
    always_comb begin
        rdy[NUM_STAGES] = OUT_READY;
        for (int k = NUM_STAGES - 1; k >= 0; k--) rdy[k] = ~v_q[k] | rdy[k+1];
    end

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        logic [DATA_WIDTH-1:0] a_in, b_in, s_in, s_nx;
        logic                  c_in, sub_in, v_in, cout;
        logic [SW-1:0]         sum;
        if (k == 0) begin : g_head
            assign a_in   = A;
            assign b_in   = (SUB == MODE_SUB) ? ~B : B;
            assign s_in   = '0;
            assign c_in   = (SUB == MODE_SUB) ? ~C0 : C0;
            assign sub_in = SUB;
            assign v_in   = IN_VALID;
        end else begin : g_body
            assign a_in   = a_q[k-1];
            assign b_in   = b_q[k-1];
            assign s_in   = s_q[k-1];
            assign c_in   = c_q[k-1];
            assign sub_in = sub_q[k-1];
            assign v_in   = v_q[k-1];
        end
        adder_slice #(.SLICE_WIDTH(SW)) u_slice (
            .a   (a_in[k*SW +: SW]),
            .b   (b_in[k*SW +: SW]),
            .cin (c_in),
            .sum (sum),
            .cout(cout)
        );
        always_comb begin
            s_nx = s_in;
            s_nx[k*SW +: SW] = sum;
        end
        assign v_d[k]   = rdy[k] ? v_in   : v_q[k];
        assign c_d[k]   = rdy[k] ? cout   : c_q[k];
        assign sub_d[k] = rdy[k] ? sub_in : sub_q[k];
        assign a_d[k]   = rdy[k] ? a_in   : a_q[k];
        assign b_d[k]   = rdy[k] ? b_in   : b_q[k];
        assign s_d[k]   = rdy[k] ? s_nx   : s_q[k];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            v_q   <= '0;
            c_q   <= '0;
            sub_q <= '0;
            a_q   <= '{default: '0};
            b_q   <= '{default: '0};
            s_q   <= '{default: '0};
        end else begin
            v_q   <= v_d;
            c_q   <= c_d;
            sub_q <= sub_d;
            a_q   <= a_d;
            b_q   <= b_d;
            s_q   <= s_d;
        end
    end

    // Flags derive from the held last stage, so they stay stable across a stall.
    assign IN_READY  = rdy[0];
    assign OUT_VALID = v_q[LS];
    assign S         = s_q[LS];
    assign CF        = v_q[LS] & (c_q[LS] ^ sub_q[LS]);
    assign OF        = v_q[LS] & (a_q[LS][MSB] == b_q[LS][MSB]) & (s_q[LS][MSB] != a_q[LS][MSB]);
    assign ZF        = v_q[LS] & ~|s_q[LS];
    assign NF        = v_q[LS] & s_q[LS][MSB];
endmodule

// File: tb/tb_pipelined_adder_subtractor.sv
// tb_pipelined_adder_subtractor: table vectors plus scoreboard-driven stall,
// sparse, reset and random runs on 4-bit/2-stage and 16-bit/{1,4,16}-stage instances.
module tb_pipelined_adder_subtractor;
    typedef struct packed {
        logic [15:0] s;
        logic        cf, of, zf, nf;
    } res_t;

    typedef struct packed {
        logic [3:0] a, b;
        logic       c0, sub;
        logic [3:0] s;
        logic       cf, of, zf, nf;
    } vec_t;

    localparam int NS4 = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0] a4, b4, s4;
    logic       c04, sub4, iv4, ir4, cf4, of4, zf4, nf4, ov4, ordy4;

    logic [15:0] a16, b16;
    logic        c016, sub16, iv16;
    logic [2:0]  ir16, cf16, of16, zf16, nf16, ov16;
    logic [15:0] s16 [3];

    int   checks = 0;
    int   errors = 0;
    res_t q4[$];
    res_t q16 [3][$];
    int   acc16 [3];
    int   sent16 = 0;
    vec_t tbl [10];
    res_t snap;
    int   acc;

    pipelined_adder_subtractor #(.DATA_WIDTH(4), .NUM_STAGES(NS4)) u_dut (
        .CLK(clk), .RST(rst), .A(a4), .B(b4), .C0(c04), .SUB(sub4),
        .IN_VALID(iv4), .IN_READY(ir4), .S(s4), .CF(cf4), .OF(of4),
        .ZF(zf4), .NF(nf4), .OUT_VALID(ov4), .OUT_READY(ordy4)
    );

    for (genvar g = 0; g < 3; g++) begin : g_w
        localparam int NS = (g == 0) ? 1 : ((g == 1) ? 4 : 16);
        pipelined_adder_subtractor #(.DATA_WIDTH(16), .NUM_STAGES(NS)) u_dut (
            .CLK(clk), .RST(rst), .A(a16), .B(b16), .C0(c016), .SUB(sub16),
            .IN_VALID(iv16), .IN_READY(ir16[g]), .S(s16[g]), .CF(cf16[g]), .OF(of16[g]),
            .ZF(zf16[g]), .NF(nf16[g]), .OUT_VALID(ov16[g]), .OUT_READY(1'b1)
        );
    end

    function automatic res_t model(int w, logic [15:0] a, logic [15:0] b, logic c0, logic sub);
        logic [16:0] m, be, sum;
        res_t r;
        m    = (17'd1 << w) - 17'd1;
        be   = sub ? (~{1'b0, b} & m) : ({1'b0, b} & m);
        sum  = ({1'b0, a} & m) + be + {16'b0, c0 ^ sub};
        r.s  = sum[15:0] & m[15:0];
        r.cf = sum[w] ^ sub;
        r.of = (a[w-1] == be[w-1]) && (r.s[w-1] != a[w-1]);
        r.zf = (r.s == 16'h0);
        r.nf = r.s[w-1];
        return r;
    endfunction

    function automatic res_t out4();
        return '{s: {12'b0, s4}, cf: cf4, of: of4, zf: zf4, nf: nf4};
    endfunction

    function automatic logic [15:0] pick16();
        int r;
        r = $urandom_range(0, 7);
        return (r == 0) ? 16'h0000 : (r == 1) ? 16'hFFFF : (r == 2) ? 16'h8000 :
               (r == 3) ? 16'h7FFF : 16'($urandom);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive now, let logic settle, then score the output transfer and the input accept.
    task automatic drive4(logic iv, logic [3:0] a, logic [3:0] b, logic c0, logic sub, logic ordy);
        iv4 = iv; a4 = a; b4 = b; c04 = c0; sub4 = sub; ordy4 = ordy;
        #1;
        if (ov4 && ordy4) begin
            if (q4.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb4_unexpected: got %h expected none", out4());
            end else chk("sb4", 32'(out4()), 32'(q4.pop_front()));
        end
        if (iv4 && ir4) q4.push_back(model(4, {12'b0, a}, {12'b0, b}, c0, sub));
    endtask

    task automatic tick4(logic iv, logic [3:0] a, logic [3:0] b, logic c0, logic sub, logic ordy);
        @(negedge clk);
        drive4(iv, a, b, c0, sub, ordy);
    endtask

    task automatic drain4();
        for (int i = 0; i < 50 && q4.size() > 0; i++) tick4(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        chk("drain4", 32'(q4.size()), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{4'b0001, 4'b0100, 1'b0, 1'b0, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{4'b1101, 4'b1100, 1'b0, 1'b0, 4'b1001, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{4'b0101, 4'b0111, 1'b0, 1'b0, 4'b1100, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{4'b1000, 4'b1011, 1'b0, 1'b0, 4'b0011, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{4'b0011, 4'b0101, 1'b0, 1'b1, 4'b1110, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{4'b0111, 4'b0111, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{4'b0000, 4'b0000, 1'b1, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[7] = '{4'b1111, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[8] = '{4'b1000, 4'b0001, 1'b0, 1'b1, 4'b0111, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[9] = '{4'b0111, 4'b0000, 1'b1, 1'b0, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b1};
        {iv4, a4, b4, c04, sub4, ordy4} = '0;
        {iv16, a16, b16, c016, sub16} = '0;
        acc16 = '{default: 0};

        @(negedge clk);
        chk("rst_ov", 32'(ov4), 32'd0);
        chk("rst_ir", 32'(ir4), 32'd1);
        chk("rst_out", 32'(out4()), 32'd0);
        chk("rst_ov16", 32'(ov16), 32'd0);
        rst = 1'b0;

        // Back-to-back table vectors: result of op t must be on the output exactly NS4 cycles later.
        for (int t = 0; t < 10 + NS4; t++) begin
            @(negedge clk);
            if (t < 10) drive4(1'b1, tbl[t].a, tbl[t].b, tbl[t].c0, tbl[t].sub, 1'b1);
            else drive4(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
            if (t < NS4) chk("vec_lat_idle", 32'(ov4), 32'd0);
            else begin
                chk("vec_ov", 32'(ov4), 32'd1);
                chk("vec_res", 32'({s4, cf4, of4, zf4, nf4}),
                    32'({tbl[t-NS4].s, tbl[t-NS4].cf, tbl[t-NS4].of, tbl[t-NS4].zf, tbl[t-NS4].nf}));
            end
        end
        drain4();

        // Output stall with IN_VALID held high: pipeline fills, then holds.
        acc = 0;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            drive4(1'b1, 4'(t + 3), 4'(2 * t + 1), t[0], t[1], 1'b0);
            if (ir4) acc++;
            if (t >= NS4) begin
                chk("stall_ir", 32'(ir4), 32'd0);
                chk("stall_ov", 32'(ov4), 32'd1);
                if (t == NS4) snap = out4();
                else chk("stall_hold", 32'(out4()), 32'(snap));
            end
        end
        chk("stall_accepts", 32'(acc), 32'(NS4));
        drain4();

        // Sparse input, random backpressure.
        for (int t = 0; t < 90; t++)
            tick4((t % 3) == 0, 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        drain4();

        // Reset with two operations in flight.
        tick4(1'b1, 4'h5, 4'h6, 1'b0, 1'b0, 1'b1);
        tick4(1'b1, 4'h9, 4'h3, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        iv4 = 1'b0;
        #1;
        chk("pre_rst_ov", 32'(ov4), 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_ov", 32'(ov4), 32'd0);
        chk("async_rst_ir", 32'(ir4), 32'd1);
        chk("async_rst_out", 32'(out4()), 32'd0);
        q4.delete();
        @(negedge clk);
        rst = 1'b0;
        drive4(1'b1, 4'hA, 4'h7, 1'b0, 1'b1, 1'b1);
        chk("post_rst_ir", 32'(q4.size()), 32'd1);
        tick4(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        chk("post_rst_nostale", 32'(ov4), 32'd0);
        tick4(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        chk("post_rst_lat", 32'(ov4), 32'd1);
        for (int t = 0; t < 4; t++) tick4(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        chk("post_rst_empty", 32'(q4.size()), 32'd0);

        // 16-bit instances, NUM_STAGES 1/4/16, random ops with extremes mixed in.
        for (int t = 0; t < 10000 + 20; t++) begin
            @(negedge clk);
            iv16  = (t < 10000) && ($urandom_range(0, 7) != 0);
            a16   = pick16();
            b16   = pick16();
            c016  = 1'($urandom);
            sub16 = 1'($urandom);
            #1;
            if (iv16) sent16++;
            for (int g = 0; g < 3; g++) begin
                if (ov16[g]) begin
                    if (q16[g].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb16_unexpected: inst %0d got %h expected none", g, s16[g]);
                    end else
                        chk("sb16", 32'(res_t'{s16[g], cf16[g], of16[g], zf16[g], nf16[g]}),
                            32'(q16[g].pop_front()));
                end
                if (iv16 && ir16[g]) begin
                    q16[g].push_back(model(16, a16, b16, c016, sub16));
                    acc16[g]++;
                end
            end
        end
        for (int g = 0; g < 3; g++) begin
            chk("acc16", 32'(acc16[g]), 32'(sent16));
            chk("drain16", 32'(q16[g].size()), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
